rs_window_ctrl: RTL

//  Sequencer in front of the Q8.8 RS engine (rs_q8_8_seq, G_POLARITY=0).
//  - Collects a valid/ready price stream into an N-deep window.
//  - Fires the engine seed (o_en) once the window is full.
//  - Then forwards one price at a time (o_valid_price), waiting for each RS result before accepting the next.
//  - Owns engine restart (o_eng_rst_n) and tags results with a sequence number.

---
 rtl/fixed_pkg.sv | 18 +
 rtl/price_window_buf.sv | 35 +++
 rtl/rs_window_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/fixed_pkg.sv
// Fixed-point types and sequencing constants shared by the RS datapath blocks.
package fixed_pkg;

  typedef logic [15:0] uq8_8_t;

  // Number of cycles the engine is held in reset on every restart.
  localparam int RSW_RST_CYCLES = 2;

  typedef enum logic [2:0] {
    RESTART   = 3'd0,
    FILL      = 3'd1,
    SEED      = 3'd2,
    SEED_WAIT = 3'd3,
    STREAM    = 3'd4,
    WAIT      = 3'd5
  } rsw_state_t;

endpackage

// File: rtl/price_window_buf.sv
// N-deep price shift register: [0] oldest, [N-1] newest, with a fill count.
module price_window_buf
  import fixed_pkg::*;
#(
  parameter int N     = 14,
  parameter int CNT_W = $clog2(N + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             clear,
  input  logic             load,
  input  logic [15:0]      din,
  output logic [15:0]      window [N],
  output logic [CNT_W-1:0] count,
  output logic             full
);

  assign full = (count == CNT_W'(N));

  // Count saturates at N so streaming shifts keep the window marked full.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < N; i++) window[i] <= '0;
      count <= '0;
    end else if (clear) begin
      for (int i = 0; i < N; i++) window[i] <= '0;
      count <= '0;
    end else if (load) begin
      for (int i = 0; i < N - 1; i++) window[i] <= window[i + 1];
      window[N-1] <= din;
      if (!full) count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/rs_window_ctrl.sv
// Window collector / sequencer in front of the Q8.8 RS engine.
// Optional engine watchdog enabled by defining RSW_WATCHDOG_EN.
module rs_window_ctrl
  import fixed_pkg::*;
#(
  parameter int N     = 14,
  parameter int SEQ_W = 16
`ifdef RSW_WATCHDOG_EN
  ,
  parameter int TIMEOUT = 64
`endif
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic [15:0]      i_price,
  input  logic             i_price_valid,
  output logic             o_price_ready,
  output logic [15:0]      o_prices [N],
  output logic             o_en,
  output logic [15:0]      o_curr_price,
  output logic             o_valid_price,
  output logic             o_eng_rst_n,
  input  logic [15:0]      i_rs_scaled,
  input  logic             i_rs_valid,
  output logic [15:0]      o_rs,
  output logic             o_rs_valid,
  output logic [SEQ_W-1:0] o_rs_seq,
  output logic             o_busy,
  output logic             o_err
);

  localparam int CNT_W     = $clog2(N + 1);
  localparam int RST_CNT_W = $clog2(RSW_RST_CYCLES + 1);

  rsw_state_t           state;
  rsw_state_t           state_nxt;
  logic [RST_CNT_W-1:0] rst_cnt;
  logic [CNT_W-1:0]     win_count;
  logic                 win_full;
  logic                 xfer;
  logic                 in_wait;
  logic                 rs_accept;
  logic                 restart_done;
  logic                 wd_timeout;

  assign o_price_ready = ((state == FILL) || (state == STREAM)) && !i_flush;
  assign xfer          = i_price_valid && o_price_ready;
  assign in_wait       = (state == SEED_WAIT) || (state == WAIT);
  assign rs_accept     = in_wait && i_rs_valid && !i_flush;
  assign restart_done  = (state == RESTART) && (rst_cnt == RST_CNT_W'(RSW_RST_CYCLES - 1));

  assign o_eng_rst_n = (state != RESTART);
  assign o_en        = (state == SEED) && win_full;
  assign o_busy      = !((state == FILL) || (state == STREAM));

  price_window_buf #(
    .N     (N),
    .CNT_W (CNT_W)
  ) u_window (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .clear  (i_flush || wd_timeout),
    .load   (xfer),
    .din    (i_price),
    .window (o_prices),
    .count  (win_count),
    .full   (win_full)
  );

  // Flush and watchdog expiry override every other transition.
  always_comb begin
    state_nxt = state;
    if (i_flush || wd_timeout) begin
      state_nxt = RESTART;
    end else begin
      case (state)
        RESTART:   if (restart_done) state_nxt = FILL;
        FILL:      if (xfer && (win_count == CNT_W'(N - 1))) state_nxt = SEED;
        SEED:      state_nxt = SEED_WAIT;
        SEED_WAIT: if (i_rs_valid) state_nxt = STREAM;
        STREAM:    if (xfer) state_nxt = WAIT;
        WAIT:      if (i_rs_valid) state_nxt = STREAM;
        default:   state_nxt = RESTART;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state   <= RESTART;
      rst_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (i_flush || wd_timeout || (state != RESTART)) rst_cnt <= '0;
      else rst_cnt <= rst_cnt + RST_CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_curr_price  <= '0;
      o_valid_price <= 1'b0;
    end else begin
      o_valid_price <= xfer && (state == STREAM);
      if (xfer && (state == STREAM)) o_curr_price <= i_price;
    end
  end

  // The seed result restarts numbering at 0; each streamed result advances it.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_rs       <= '0;
      o_rs_valid <= 1'b0;
      o_rs_seq   <= '0;
    end else begin
      o_rs_valid <= rs_accept;
      if (i_flush) begin
        o_rs_seq <= '0;
      end else if (rs_accept) begin
        o_rs     <= i_rs_scaled;
        o_rs_seq <= (state == SEED_WAIT) ? '0 : o_rs_seq + SEQ_W'(1);
      end
    end
  end

`ifdef RSW_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wd_cnt;

  assign wd_timeout = in_wait && !i_rs_valid && (wd_cnt == WD_W'(TIMEOUT - 1));

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wd_cnt <= '0;
      o_err  <= 1'b0;
    end else begin
      if (wd_timeout) o_err <= 1'b1;
      if (!in_wait || (state_nxt != state)) wd_cnt <= '0;
      else wd_cnt <= wd_cnt + WD_W'(1);
    end
  end
`else
  assign wd_timeout = 1'b0;
  assign o_err      = 1'b0;
`endif

endmodule
